// File: rtl/clk_en_pkg.sv
// Shared constants for the clock-enable generator: default widths, the
// legacy divisors of the serial/PWM/PID consumers and their channel slots.
// Optional feature macro: CLK_EN_PHASE_EN (per-channel phase offset on sync_clr).
package clk_en_pkg;

    localparam int CNT_W_DEF  = 32;
    localparam int NUM_CH_DEF = 3;

    // Divisors of the 100 MHz system clock used by the original consumers.
    localparam logic [31:0] DIV_SERIAL = 32'd652;
    localparam logic [31:0] DIV_PWM    = 32'd4001;
    localparam logic [31:0] DIV_PID    = 32'd8000001;

    // Channel slots of those consumers in the default configuration.
    localparam int CH_SERIAL = 0;
    localparam int CH_PWM    = 1;
    localparam int CH_PID    = 2;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_en_channel.sv
// One enable channel: free-running period counter, active and shadow divisor,
// pending-update flag and the registered single-cycle enable pulse.
// A new divisor only takes over at a period boundary (terminal count), while
// the channel is stopped/stalled, or on sync_clr, so no runt periods occur.
// Optional feature macro: CLK_EN_PHASE_EN adds a phase offset loaded on sync_clr.
module clk_en_channel #(
    parameter int               CNT_W   = 32,
    parameter logic [CNT_W-1:0] RST_DIV = '0
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr_stb,
    input  logic [CNT_W-1:0] wr_div,
`ifdef CLK_EN_PHASE_EN
    input  logic [CNT_W-1:0] wr_phase,
`endif
    output logic             pending,
    output logic             ce
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_div_q, active_div_d;
    logic [CNT_W-1:0] shadow_div_q, shadow_div_d;
    logic             pending_q, pending_d;
    logic             ce_q, ce_d;
    logic             div_zero;
    logic             at_term;
`ifdef CLK_EN_PHASE_EN
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] shadow_phase_q, shadow_phase_d;
`endif

    // Next-state of divisor bookkeeping and the period counter.
    always_comb begin
        cnt_d        = cnt_q;
        active_div_d = active_div_q;
        shadow_div_d = shadow_div_q;
        pending_d    = pending_q;
        ce_d         = 1'b0;
`ifdef CLK_EN_PHASE_EN
        phase_d        = phase_q;
        shadow_phase_d = shadow_phase_q;
`endif

        div_zero = (active_div_q == '0);
        // >= rather than == : a divisor applied while the channel was frozen
        // may land below the held count; this ends that period on the next
        // enabled edge instead of letting the counter wrap.
        at_term  = !div_zero && (cnt_q >= active_div_q - CNT_W'(1));

        if (sync_clr && wr_stb) begin
            // A write coinciding with sync_clr takes effect at once.
            active_div_d = wr_div;
            shadow_div_d = wr_div;
            pending_d    = 1'b0;
`ifdef CLK_EN_PHASE_EN
            phase_d        = wr_phase;
            shadow_phase_d = wr_phase;
`endif
        end else begin
            if (pending_q && (sync_clr || !en || div_zero || at_term)) begin
                active_div_d = shadow_div_q;
                pending_d    = 1'b0;
`ifdef CLK_EN_PHASE_EN
                phase_d      = shadow_phase_q;
`endif
            end
            // Only reachable with pending_q=0, since the port is then ready.
            if (wr_stb) begin
                shadow_div_d = wr_div;
                pending_d    = 1'b1;
`ifdef CLK_EN_PHASE_EN
                shadow_phase_d = wr_phase;
`endif
            end
        end

        if (sync_clr) begin
`ifdef CLK_EN_PHASE_EN
            cnt_d = (phase_d < active_div_d) ? phase_d : '0;
`else
            cnt_d = '0;
`endif
        end else if (!en || div_zero) begin
            cnt_d = cnt_q;
        end else if (at_term) begin
            cnt_d = '0;
            ce_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset restores the default divisor and drops any update.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            active_div_q <= RST_DIV;
            shadow_div_q <= '0;
            pending_q    <= 1'b0;
            ce_q         <= 1'b0;
`ifdef CLK_EN_PHASE_EN
            phase_q        <= '0;
            shadow_phase_q <= '0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            active_div_q <= active_div_d;
            shadow_div_q <= shadow_div_d;
            pending_q    <= pending_d;
            ce_q         <= ce_d;
`ifdef CLK_EN_PHASE_EN
            phase_q        <= phase_d;
            shadow_phase_q <= shadow_phase_d;
`endif
        end
    end

    assign pending = pending_q;
    assign ce      = ce_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator. Each channel emits a one-cycle pulse
// every DIV clk_in cycles; divisors are rewritten through a valid/ready port
// and take effect glitch-free at the next period boundary.
// Optional feature macro: CLK_EN_PHASE_EN (adds wr_phase port).
module clk_enable_gen
    import clk_en_pkg::*;
#(
    parameter int                      NUM_CH   = NUM_CH_DEF,
    parameter int                      CNT_W    = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_DIVS = {DIV_PID, DIV_PWM, DIV_SERIAL},
    localparam int                     CH_W     = ch_idx_w(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_clr,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
`ifdef CLK_EN_PHASE_EN
    input  logic [CNT_W-1:0]  wr_phase,
`endif
    output logic [NUM_CH-1:0] ce_out
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_stb;
    logic              wr_fire;

    // Ready mux: a channel with an update still waiting refuses new writes;
    // an index past the last channel is always accepted and dropped.
    always_comb begin
        wr_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ch == CH_W'(i)) begin
                wr_ready = ~pending[i];
            end
        end
    end

    assign wr_fire = wr_valid & wr_ready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign wr_stb[gi] = wr_fire && (wr_ch == CH_W'(gi));

            clk_en_channel #(
                .CNT_W   (CNT_W),
                .RST_DIV (DEF_DIVS[gi*CNT_W +: CNT_W])
            ) u_ch (
                .clk_in   (clk_in),
                .rst_n    (rst_n),
                .en       (ch_en[gi]),
                .sync_clr (sync_clr),
                .wr_stb   (wr_stb[gi]),
                .wr_div   (wr_div),
`ifdef CLK_EN_PHASE_EN
                .wr_phase (wr_phase),
`endif
                .pending  (pending[gi]),
                .ce       (ce_out[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: NUM_CH=3, DEF_DIVS={1,3,5}. Stimulus pushes the
// hand-computed edge numbers of every expected pulse into per-channel queues;
// a monitor pops one entry per observed pulse and flags extra/missing pulses.
module tb_clk_enable_gen;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 32;
    localparam int CH_W   = 2;

    logic              clk_in   = 1'b0;
    logic              rst_n    = 1'b0;
    logic [NUM_CH-1:0] ch_en    = 3'b111;
    logic              sync_clr = 1'b0;
    logic              wr_valid = 1'b0;
    logic [CH_W-1:0]   wr_ch    = '0;
    logic [CNT_W-1:0]  wr_div   = '0;
`ifdef CLK_EN_PHASE_EN
    logic [CNT_W-1:0]  wr_phase = '0;
`endif
    logic              wr_ready;
    logic [NUM_CH-1:0] ce_out;

    int checks = 0;
    int errors = 0;
    int edge_n;
    int exp_q[NUM_CH][$];

    clk_enable_gen #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DEF_DIVS ({32'd1, 32'd3, 32'd5})
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .ch_en    (ch_en),
        .sync_clr (sync_clr),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_ch    (wr_ch),
        .wr_div   (wr_div),
`ifdef CLK_EN_PHASE_EN
        .wr_phase (wr_phase),
`endif
        .ce_out   (ce_out)
    );

    always #5 clk_in = ~clk_in;

    // Edge number since reset release: edge 1 is the first posedge after it.
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    // Monitor: one queue entry consumed per observed pulse.
    always @(negedge clk_in) begin : mon
        int e;
        if (rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ce_out[c]) begin
                    checks++;
                    if (exp_q[c].size() == 0) begin
                        errors++;
                        $display("FAIL ce%0d_pulse: pulse at edge %0d, none expected", c, edge_n);
                    end else begin
                        e = exp_q[c].pop_front();
                        if (e != edge_n) begin
                            errors++;
                            $display("FAIL ce%0d_pulse: pulse at edge %0d, expected edge %0d", c, edge_n, e);
                        end else begin
                            $display("ce%0d pulse at edge %0d ok", c, edge_n);
                        end
                    end
                end else if (exp_q[c].size() > 0 && exp_q[c][0] <= edge_n) begin
                    checks++;
                    errors++;
                    e = exp_q[c].pop_front();
                    $display("FAIL ce%0d_missing: no pulse by edge %0d, expected at edge %0d", c, edge_n, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("%s = %0d ok", name, act);
        end
    endtask

    task automatic push_seq(input int c, input int first, input int step, input int last);
        for (int e = first; e <= last; e += step) exp_q[c].push_back(e);
    endtask

    task automatic to_edge(input int n);
        while (edge_n < n) @(negedge clk_in);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_in);
        chk("rst_ce_out", 32'(ce_out), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);

        // ch0: div 5 until edge 15, div 2 after, then div 5 from sync_clr at 42
        push_seq(0, 5, 5, 15);
        push_seq(0, 17, 2, 41);
        push_seq(0, 47, 5, 52);
        // ch1: div 3, frozen 17..23, div 0 from 28, div 4 from 32, div 3 from 42
        push_seq(1, 3, 3, 15);
        push_seq(1, 25, 3, 28);
        push_seq(1, 36, 4, 40);
        push_seq(1, 45, 3, 51);
        // ch2: div 1, high every edge except the sync_clr edge
        push_seq(2, 1, 1, 41);
        push_seq(2, 43, 1, 53);

        rst_n = 1'b1;

        to_edge(11);
        chk("ready_before_wr_ch0", 32'(wr_ready), 1);
        wr_valid = 1'b1; wr_ch = 2'd0; wr_div = 32'd2;

        to_edge(12);
        wr_valid = 1'b0;
        #1 chk("ready_ch0_pending", 32'(wr_ready), 0);
        wr_valid = 1'b1; wr_ch = 2'd3; wr_div = 32'd1;
        #1 chk("ready_out_of_range", 32'(wr_ready), 1);

        to_edge(13);
        wr_valid = 1'b0; wr_ch = 2'd0;

        to_edge(14);
        chk("ready_ch0_still_pending", 32'(wr_ready), 0);
        to_edge(15);
        chk("ready_ch0_applied", 32'(wr_ready), 1);

        to_edge(16);
        ch_en[1] = 1'b0;
        to_edge(23);
        ch_en[1] = 1'b1;

        to_edge(26);
        wr_valid = 1'b1; wr_ch = 2'd1; wr_div = 32'd0;
        to_edge(27);
        wr_valid = 1'b0;
        #1 chk("ready_ch1_pending_div0", 32'(wr_ready), 0);
        to_edge(28);
        chk("ready_ch1_div0_applied", 32'(wr_ready), 1);

        to_edge(30);
        wr_valid = 1'b1; wr_div = 32'd4;
        to_edge(31);
        wr_valid = 1'b0;
        #1 chk("ready_ch1_pending_div4", 32'(wr_ready), 0);
        to_edge(32);
        chk("ready_ch1_stall_applied", 32'(wr_ready), 1);

        to_edge(40);
        wr_valid = 1'b1; wr_ch = 2'd1; wr_div = 32'd3;
        to_edge(41);
        chk("ready_ch1_pending_pre_clr", 32'(wr_ready), 0);
        sync_clr = 1'b1; wr_ch = 2'd0; wr_div = 32'd5;
        #1 chk("ready_ch0_at_clr", 32'(wr_ready), 1);

        to_edge(42);
        sync_clr = 1'b0; wr_valid = 1'b0;
        chk("ready_ch0_after_clr", 32'(wr_ready), 1);
        wr_ch = 2'd1;
        #1 chk("ready_ch1_after_clr", 32'(wr_ready), 1);

        to_edge(51);
        wr_valid = 1'b1; wr_ch = 2'd1; wr_div = 32'd7;
        to_edge(52);
        wr_valid = 1'b0;
        #1 chk("ready_ch1_pending_pre_rst", 32'(wr_ready), 0);

        to_edge(53);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_ce_out", 32'(ce_out), 0);
        chk("async_rst_ready_ch1", 32'(wr_ready), 1);
        for (int c = 0; c < NUM_CH; c++) chk($sformatf("drain_q%0d", c), 32'(exp_q[c].size()), 0);
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();

        // After release the defaults {5,3,1} must be back and the ch1 write gone.
        push_seq(0, 5, 5, 15);
        push_seq(1, 3, 3, 15);
        push_seq(2, 1, 1, 16);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;

        to_edge(16);
        #1;
        for (int c = 0; c < NUM_CH; c++) chk($sformatf("final_q%0d", c), 32'(exp_q[c].size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
